// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizes for the register-file micro-op sequencer.
package regfile_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int IMM_W  = 8;

  typedef enum logic [1:0] {
    OP_MOVI = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_AND  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational result/flag unit for MOVI/MOV/ADD/AND.
module rf_alu #(
  parameter int DW = 16
) (
  input  logic [1:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [7:0]    i_imm,
  output logic [DW-1:0] o_c,
  output logic          o_n,
  output logic          o_z,
  output logic          o_v
);
  import regfile_ctrl_pkg::*;

  logic [DW-1:0] w_sum;
  logic          w_is_add;

  assign w_sum    = i_a + i_b;
  assign w_is_add = (op_e'(i_op) == OP_ADD);

  always_comb begin
    o_c = '0;
    case (op_e'(i_op))
      OP_MOVI: o_c = {{(DW-8){i_imm[7]}}, i_imm};
      OP_MOV:  o_c = i_a;
      OP_ADD:  o_c = w_sum;
      OP_AND:  o_c = i_a & i_b;
      default: o_c = '0;
    endcase
  end

  // Overflow only when both addends share a sign the sum does not.
  assign o_n = o_c[DW-1];
  assign o_z = (o_c == '0);
  assign o_v = w_is_add & (i_a[DW-1] == i_b[DW-1]) & (w_sum[DW-1] != i_a[DW-1]);

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer: latches one instruction, reads sources through the regfile read
// port, computes via rf_alu, then writes back and pulses done.
module regfile_ctrl #(
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [7:0]        in_imm,
  output logic [ADDR_W-1:0] rf_readnum,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              done,
  output logic [2:0]        flags
);
  import regfile_ctrl_pkg::*;

  state_e            r_state, w_next;
  op_e               r_op;
  logic [ADDR_W-1:0] r_rd, r_rs, r_rt;
  logic [7:0]        r_imm;
  logic [DATA_W-1:0] r_a, r_b, r_c;
  logic [2:0]        r_flags;

  logic              w_xfer;
  logic [DATA_W-1:0] w_c;
  logic              w_n, w_z, w_v;

  assign w_xfer = in_valid & (r_state == S_IDLE);

  rf_alu #(.DW(DATA_W)) u_alu (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .i_imm (r_imm),
    .o_c   (w_c),
    .o_n   (w_n),
    .o_z   (w_z),
    .o_v   (w_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = (op_e'(in_op) == OP_MOVI) ? S_EXEC : S_READ_A;
      S_READ_A: w_next = (r_op == OP_MOV) ? S_EXEC : S_READ_B;
      S_READ_B: w_next = S_EXEC;
      S_EXEC:   w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // rf_write/done are also gated by rst_n so a reset drops them combinationally.
  always_comb begin
    in_ready    = (r_state == S_IDLE);
    rf_readnum  = '0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_data_in  = '0;
    done        = 1'b0;
    case (r_state)
      S_READ_A: rf_readnum = r_rs;
      S_READ_B: rf_readnum = r_rt;
      S_WRITE: begin
        rf_write    = rst_n;
        rf_writenum = r_rd;
        rf_data_in  = r_c;
        done        = rst_n;
      end
      default: ;
    endcase
  end

  assign flags = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_MOVI;
      r_rd    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_imm   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_flags <= '0;
    end else begin
      if (w_xfer) begin
        r_op  <= op_e'(in_op);
        r_rd  <= in_rd;
        r_rs  <= in_rs;
        r_rt  <= in_rt;
        r_imm <= in_imm;
      end
      if (r_state == S_READ_A) r_a <= rf_data_out;
      if (r_state == S_READ_B) r_b <= rf_data_out;
      if (r_state == S_EXEC) begin
        r_c     <= w_c;
        r_flags <= {w_n, w_z, w_v};
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x16 regfile on the rf_* ports.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic [7:0]  in_imm;
  logic [2:0]  rf_readnum, rf_writenum;
  logic [15:0] rf_data_out, rf_data_in;
  logic        rf_write, done;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  regfile_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .done(done), .flags(flags)
  );

  // Regfile: combinational read, clocked write; bench pokes share the write port.
  logic [15:0] rf [8];
  logic        pk_en = 1'b0;
  logic [2:0]  pk_addr = '0;
  logic [15:0] pk_val = '0;
  assign rf_data_out = rf[rf_readnum];
  always @(posedge clk) begin
    if (rf_write)   rf[rf_writenum] <= rf_data_in;
    else if (pk_en) rf[pk_addr] <= pk_val;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    bit          pk;
    logic [1:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic [15:0] val;
    int          lat;
    logic [2:0]  fl;
  } vec_t;

  vec_t vt[$];

  task automatic poke(input logic [2:0] a, input logic [15:0] v);
    pk_en = 1'b1; pk_addr = a; pk_val = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run_instr(input vec_t v);
    int lat = 0;
    bit rdy_bad = 0;
    chk("ready_before", in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_rd = v.rd; in_rs = v.rs; in_rt = v.rt; in_imm = v.imm;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_rd = 3'($urandom);
    in_rs = 3'($urandom); in_rt = 3'($urandom); in_imm = 8'($urandom);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && v.op != 2'b00) chk("readnum_rs", rf_readnum, v.rs);
      if (!done && in_ready) rdy_bad = 1;
    end while (!done && lat < 10);
    chk("latency", lat, v.lat);
    chk("ready_low_busy", rdy_bad, 0);
    chk("rf_write", rf_write, 1);
    chk("writenum", rf_writenum, v.rd);
    chk("data_in", rf_data_in, v.val);
    chk("readnum_idle", rf_readnum, 0);
    chk("flags", flags, v.fl);
    @(negedge clk);
    chk("rf_value", rf[v.rd], v.val);
    chk("done_low", done, 0);
    chk("ready_after", in_ready, 1);
  endtask

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return 2;
      2'b01:   return 3;
      default: return 4;
    endcase
  endfunction

  bit wr_watch = 0, wr_seen = 0;
  always @(rf_write) if (wr_watch && rf_write) wr_seen = 1;

  initial begin
    logic [15:0] old_r4;
    int ctr, acc, dn;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_write", rf_write, 0);
    chk("rst_readnum", rf_readnum, 0);
    chk("rst_writenum", rf_writenum, 0);
    chk("rst_data_in", rf_data_in, 0);
    chk("rst_flags", flags, 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) poke(3'(i), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //             pk op     rd    rs    rt    imm     val       lat fl{N,Z,V}
    vt.push_back('{0, 2'b00, 3'd1, 3'd0, 3'd0, 8'h80, 16'hFF80, 2, 3'b100});
    vt.push_back('{0, 2'b00, 3'd2, 3'd0, 3'd0, 8'h05, 16'h0005, 2, 3'b000});
    vt.push_back('{0, 2'b00, 3'd3, 3'd0, 3'd0, 8'h07, 16'h0007, 2, 3'b000});
    vt.push_back('{0, 2'b10, 3'd4, 3'd2, 3'd3, 8'h00, 16'h000C, 4, 3'b000});
    vt.push_back('{0, 2'b10, 3'd6, 3'd1, 3'd1, 8'h00, 16'hFF00, 4, 3'b100});
    vt.push_back('{0, 2'b01, 3'd1, 3'd4, 3'd0, 8'h00, 16'h000C, 3, 3'b000});
    vt.push_back('{1, 2'b00, 3'd5, 3'd0, 3'd0, 8'h00, 16'h7FFF, 0, 3'b000});
    vt.push_back('{1, 2'b00, 3'd6, 3'd0, 3'd0, 8'h00, 16'h0001, 0, 3'b000});
    vt.push_back('{0, 2'b10, 3'd5, 3'd5, 3'd6, 8'h00, 16'h8000, 4, 3'b101});
    vt.push_back('{1, 2'b00, 3'd2, 3'd0, 3'd0, 8'h00, 16'h00F0, 0, 3'b000});
    vt.push_back('{1, 2'b00, 3'd3, 3'd0, 3'd0, 8'h00, 16'h0F00, 0, 3'b000});
    vt.push_back('{0, 2'b11, 3'd7, 3'd2, 3'd3, 8'h00, 16'h0000, 4, 3'b010});
    vt.push_back('{0, 2'b01, 3'd0, 3'd7, 3'd0, 8'h00, 16'h0000, 3, 3'b010});
    vt.push_back('{1, 2'b00, 3'd2, 3'd0, 3'd0, 8'h00, 16'h8000, 0, 3'b000});
    vt.push_back('{1, 2'b00, 3'd3, 3'd0, 3'd0, 8'h00, 16'h8000, 0, 3'b000});
    vt.push_back('{0, 2'b10, 3'd3, 3'd2, 3'd3, 8'h00, 16'h0000, 4, 3'b011});
    vt.push_back('{0, 2'b00, 3'd4, 3'd0, 3'd0, 8'h7F, 16'h007F, 2, 3'b000});

    foreach (vt[i]) begin
      if (vt[i].pk) poke(vt[i].rd, vt[i].val);
      else          run_instr(vt[i]);
    end

    // Reset during EXEC of an ADD into R4: no write, R4 keeps 0x007F.
    old_r4 = rf[4];
    in_valid = 1'b1; in_op = 2'b10; in_rd = 3'd4; in_rs = 3'd5; in_rt = 3'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    wr_watch = 1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_write", rf_write, 0);
    chk("mid_rst_flags", flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr_watch = 0;
    chk("abort_no_write", wr_seen, 0);
    chk("abort_rd_kept", rf[4], old_r4);
    chk("abort_ready", in_ready, 1);

    // Random in_valid: model tracks busy window, accepts and done pulses.
    ctr = 0; acc = 0; dn = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_ready", in_ready, (ctr == 0));
      chk("rnd_done", done, (ctr == 1));
      if (done) dn++;
      if (c < 360) begin
        in_valid = 1'($urandom); in_op = 2'($urandom); in_rd = 3'($urandom);
        in_rs = 3'($urandom); in_rt = 3'($urandom); in_imm = 8'($urandom);
      end else in_valid = 1'b0;
      @(posedge clk);
      if (in_valid && ctr == 0) begin ctr = lat_of(in_op); acc++; end
      else if (ctr > 0) ctr--;
      @(negedge clk);
    end
    chk("rnd_done_per_accept", dn, acc);
    chk("rnd_some_accepted", (acc > 10), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Micro-op sequencer that drives the 8×16 register file's read and write ports.
- Accepts one register-transfer instruction at a time over a valid/ready handshake.
- Reads source registers through the regfile's combinational read port and computes the result.
- Writes the result back through the regfile's clocked write port, then reports completion and flags.
- Sits between the instruction source and the regfile as that port's sole initiator.

## Interface
Parameters:
- DATA_W, 16, register and datapath width
- ADDR_W, 3, register index width (8 registers)

Ports:
- clk  input  1  rising-edge clock, shared with the regfile
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction present
- in_ready  output  1  controller can accept an instruction
- in_op  input  2  opcode: 00 MOVI, 01 MOV, 10 ADD, 11 AND
- in_rd  input  ADDR_W  destination register
- in_rs  input  ADDR_W  first source register
- in_rt  input  ADDR_W  second source register
- in_imm  input  8  immediate (MOVI only)
- rf_readnum  output  ADDR_W  to regfile readnum
- rf_data_out  input  DATA_W  from regfile data_out (combinational read)
- rf_writenum  output  ADDR_W  to regfile writenum
- rf_write  output  1  to regfile write
- rf_data_in  output  DATA_W  to regfile data_in
- done  output  1  one-cycle pulse, asserted in the WRITE cycle
- flags  output  3  {N, Z, V} of the last completed instruction

## Operation
- Handshake:
  - Transfer occurs on a clk edge with in_valid & in_ready.
  - On transfer, in_op/rd/rs/rt/imm are latched.
  - Inputs are don't-care at all other times.
- FSM states: IDLE, READ_A, READ_B, EXEC, WRITE.
- Transitions:
  - IDLE: on transfer, MOVI→EXEC; MOV→READ_A; ADD/AND→READ_A.
  - READ_A: rf_readnum=rs; A←rf_data_out at edge. Then MOV→EXEC; ADD/AND→READ_B.
  - READ_B: rf_readnum=rt; B←rf_data_out at edge; →EXEC.
  - EXEC: C←result at edge; flags updated at the same edge; →WRITE.
  - WRITE: rf_write=1, rf_writenum=rd, rf_data_in=C, done=1; →IDLE.
- Results:
  - MOVI: C = sign-extended imm8.
  - MOV: C = A.
  - ADD: C = A+B mod 2^DATA_W.
  - AND: C = A&B.
- Flags:
  - N = C[MSB].
  - Z = (C==0).
  - V = signed overflow for ADD, 0 for all other ops.
- in_ready=1 only in IDLE.
- rf_write=1 only in WRITE.
- rf_readnum = 0 outside READ_A/READ_B.
- rd equal to rs/rt is legal: sources are captured before the write.

## Timing
- Cycle 0 is the transfer edge. Latency from transfer to done:
  - ADD/AND: 4 cycles (READ_A 1, READ_B 2, EXEC 3, WRITE 4).
  - MOV: 3 cycles.
  - MOVI: 2 cycles.
- The regfile register updates on the edge ending the WRITE cycle.
- in_ready rises the cycle after WRITE. Peak throughput is one ADD per 5 cycles.
- Read-after-write: the next instruction's READ_A follows the write edge and must see the new value.
- Reset values (asynchronous on rst_n low):
  - state=IDLE, in_ready=1.
  - rf_write=0, done=0.
  - rf_readnum=0, rf_writenum=0, rf_data_in=0.
  - flags=0; A, B, C=0.
- Reset mid-operation aborts the instruction with no write issued. rf_write is forced low immediately, not at the next edge.
- in_valid held high in IDLE after WRITE starts the next instruction with no bubble beyond the mandatory IDLE cycle.

## Structure
- Package regfile_ctrl_pkg holds:
  - op_e enum (MOVI, MOV, ADD, AND)
  - state_e enum
  - constants DATA_W, ADDR_W
- One combinational sub-module, rf_alu:
  - inputs: op, A, B, imm
  - outputs: C, N, Z, V
- The FSM and the operand/result registers live in regfile_ctrl.
- The bench instantiates the existing regfile on the rf_* ports.

## Test plan
- Reset, then MOVI rd=1 imm=0x80:
  - done at cycle 2, writing R1=0xFF80.
  - flags N=1, Z=0, V=0.
- MOVI R2=0x05, MOVI R3=0x07, then ADD rd=4 rs=2 rt=3:
  - R4=0x000C, done 4 cycles after the ADD transfer.
  - in_ready low during the ADD.
- R5=0x7FFF, R6=0x0001, ADD rd=5 rs=5 rt=6:
  - R5=0x8000 (rd==rs overwrite).
  - flags N=1, V=1.
- AND of R2=0x00F0 and R3=0x0F00 into R7:
  - R7=0x0000, Z=1.
  - Then MOV rd=0 rs=7 reads the new R7 (back-to-back RAW): R0=0x0000.
- Assert rst_n low during the EXEC state of an ADD:
  - rf_write never rises and the destination register is unchanged.
  - in_ready=1 and done=0 while in reset.
- in_valid toggling randomly while busy:
  - No instruction is accepted outside IDLE.
  - Exactly one done per accepted instruction.
